// File: rtl/serial_mult_seq.sv
// Frame sequencer for a 16-bit serial/parallel multiplier core: flushes the core,
// feeds operands over valid/ready, and collects the serial product into a word.
module serial_mult_seq #(
    parameter int WIDTH = 16,
    parameter int FRAME = 2 * WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   mult_a,
    output logic               mult_x,
    input  logic               mult_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_FILL = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] b_sh;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mult_x     = 1'b0;
        case (state)
            FLUSH: begin
                if (cnt_last) state_next = IDLE;
            end
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                // Multiplier bits for the first half of the frame, zero-fill after.
                mult_x = (cnt < CNT_FILL) ? b_sh[0] : 1'b0;
                if (cnt_last) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = FLUSH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FLUSH;
        else       state <= state_next;
    end

    // NOTE: the core has no reset; FLUSH drives zeros for a full frame so its
    // accumulator drains before the first operation is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            mult_a    <= '0;
            b_sh      <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    mult_a <= '0;
                    cnt    <= cnt_last ? '0 : cnt + 1'b1;
                end
                IDLE: begin
                    if (in_valid) begin
                        mult_a <= a_in;
                        b_sh   <= b_in;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    b_sh    <= b_sh >> 1;
                    product <= {mult_p, product[2*WIDTH-1:1]};
                    cnt     <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last) out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mult_seq.sv
// Bench for serial_mult_seq: includes a behavioural serial/parallel core with an
// unreset accumulator and compares products against plain a*b arithmetic.
module tb_serial_mult_seq;

    localparam int W     = 16;
    localparam int FRAME = 2 * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [W-1:0]  mult_a;
    logic          mult_x;
    logic          mult_p;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    serial_mult_seq #(.WIDTH(W), .FRAME(FRAME)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mult_a    (mult_a),
        .mult_x    (mult_x),
        .mult_p    (mult_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clock = ~clock;

    // Core stand-in: the serial product bit is the LSB of acc + x*A, and the
    // accumulator keeps the rest. It powers up holding garbage.
    logic [W-1:0] core_acc;
    logic [W:0]   core_sum;
    initial core_acc = W'($urandom);
    assign core_sum = {1'b0, core_acc} + (mult_x ? {1'b0, mult_a} : '0);
    assign mult_p   = core_sum[0];
    always @(posedge clock) core_acc <= core_sum[W:1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where reset has just dropped.
    task automatic check_flush();
        for (int i = 1; i <= FRAME; i++) begin
            check("flush_in_ready", in_ready, 0);
            check("flush_mult_x", mult_x, 0);
            check("flush_mult_a", mult_a, 0);
            check("flush_out_valid", out_valid, 0);
            @(negedge clock);
        end
        check("flush_done_in_ready", in_ready, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit ready_early, input bit noise);
        logic [2*W-1:0] exp_p;
        logic [W-1:0]   bs;
        logic           exp_x;
        int             lat;
        exp_p = (2*W)'(a) * (2*W)'(b);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = ready_early;
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clock);
        check("accept_in_ready", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        if (!noise) in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            bs    = b >> (lat - 1);
            exp_x = (lat <= W) ? bs[0] : 1'b0;
            check("run_mult_a", mult_a, a);
            check("run_mult_x", mult_x, exp_x);
            check("run_in_ready", in_ready, 0);
            if (noise) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, FRAME + 1);
        check("product", product, exp_p);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_out_valid", out_valid, 1);
            check("stall_product", product, exp_p);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) @(negedge clock);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        check("reset_mult_a", mult_a, 0);
        check("reset_mult_x", mult_x, 0);
        reset = 1'b0;
        check_flush();

        // out_ready already high before the result exists.
        run_op(16'h0003, 16'h0005, 0, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 2, 1'b0, 1'b0);
        // Back-to-back with a stalled first result.
        run_op(16'h1234, 16'h0010, 5, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0001, 0, 1'b0, 1'b0);

        // Reset in the middle of a RUN: nothing emitted, full flush follows.
        in_valid = 1'b1;
        a_in     = 16'h00FF;
        b_in     = 16'h00FF;
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clock);
        check("abort_accept", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("abort_run_out_valid", out_valid, 0);
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_mult_a", mult_a, 0);
        check("abort_mult_x", mult_x, 0);
        check("abort_product", product, 0);
        @(negedge clock);
        reset = 1'b0;
        check_flush();
        run_op(16'h0002, 16'h0003, 0, 1'b0, 1'b0);

        // New operands offered during RUN must be ignored.
        run_op(16'h2468, 16'h1357, 1, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            ra = W'($urandom_range(0, 16'h7FFF));
            rb = W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, k[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_mult_seq.md
Name: serial_mult_seq

Overview:
- Frame sequencer wrapped around the 16-bit serial/parallel multiplier core.
- Upstream side: accepts a parallel operand pair over a valid/ready handshake and holds multiplicand A on the core's parallel inputs. Serialises multiplier B onto the core's serial input, LSB first.
- Downstream side: collects the core's serial product bit every cycle into a 32-bit word and presents it over a valid/ready handshake.
- The core has no reset. This block guarantees the core's accumulator is flushed before the first accepted operation.

Parameters:
- WIDTH, 16: operand width; must match the core's parallel width.
- FRAME, 2*WIDTH: cycles per operation (WIDTH multiplier bits plus WIDTH zero-fill bits).

Ports:
- clock  in  1  rising-edge clock, shared with the multiplier core
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a_in  in  WIDTH  multiplicand A
- b_in  in  WIDTH  multiplier B
- mult_a  out  WIDTH  to core parallel inputs (core ports 3..18, LSB on 3)
- mult_x  out  1  to core serial input (core port 1)
- mult_p  in  1  from core serial product output (core port 36)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  assembled product, bit 0 = first serial bit

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clock, reset port is reset.
- All outputs registered except in_ready and mult_x, which are decoded from state. mult_x is state-decoded so the core samples it in the same cycle the bit is driven.
- Reset values: state=FLUSH, cnt=0, mult_a=0, b_sh=0, product=0, out_valid=0, in_ready=0, mult_x=0.
- States:
  - FLUSH: mult_a=0, mult_x=0 for FRAME cycles (cnt 0..FRAME-1), then go to IDLE. mult_p is ignored.
  - IDLE: in_ready=1. On in_valid, load mult_a<=a_in, b_sh<=b_in, cnt<=0, and go to RUN.
  - RUN: mult_x = b_sh[0] while cnt<WIDTH, else 0. Each cycle: b_sh shifts right, product <= {mult_p, product[2W-1:1]}, cnt++.
    - On cnt==FRAME-1, go to HOLD and set out_valid=1.
    - mult_a stays stable for the whole RUN.
  - HOLD: product and out_valid stay stable until out_ready. On out_ready, clear out_valid and go to IDLE.
- Latency: acceptance to out_valid is exactly FRAME+1 cycles (33 at default). Minimum issue interval is FRAME+2 cycles.
- mult_p is combinational in the core from mult_x. It is captured in the same cycle mult_x is driven; there is no extra pipeline slot.
- Flush invariant: after FRAME cycles of zero serial input, the core accumulator is all zero. The RUN zero-fill half therefore leaves the core clean for the next frame, so no re-flush is needed between operations.
- in_ready=0 in FLUSH, RUN and HOLD. in_valid is ignored in those states and the operands are not captured.
- out_ready while out_valid=0 has no effect.
- In HOLD, in_ready=0. The block does not overlap frames, which avoids collisions on the core's shared accumulator.
- Reset asserted mid-RUN or mid-HOLD:
  - The operation is abandoned and no product is emitted.
  - The block returns to FLUSH immediately, on the asynchronous edge.
  - A full FRAME flush runs after deassertion before in_ready rises.
- Arithmetic contract: for a_in[WIDTH-1]=0, product == a_in*b_in, unsigned, exact in 2*WIDTH bits. For a_in MSB=1, product is whatever the core's sign handling yields; the scoreboard takes its expected value from the core model.
- cnt width is clog2(FRAME). There is no wrap-around beyond FRAME-1: transition to HOLD/IDLE occurs on the terminal count.

Test Plan:
- Reset release -> in_ready stays 0 for 32 cycles, mult_x=0 and mult_a=0 throughout; in_ready=1 on cycle 33.
- a_in=0x0003, b_in=0x0005, out_ready=1 -> out_valid asserts 33 cycles after acceptance with product=0x0000000F; in_ready returns the next cycle.
- a_in=0x7FFF, b_in=0xFFFF -> product=0x7FFE8001.
- Back-to-back: two pairs (0x1234,0x0010) then (0x0001,0x0001), with out_ready held low 5 cycles on the first result -> product 0x00012340 held stable during stall, then 0x00000001. Second result is unaffected by the previous core state.
- Reset pulse at cycle 10 of RUN for (0x00FF,0x00FF) -> no out_valid; a 32-cycle flush follows. A subsequent (0x0002,0x0003) yields 0x00000006, proving the core was cleaned.
- in_valid asserted during RUN with different operands -> ignored; the current product is unchanged and mult_a holds for all 32 cycles.
